// File: rtl/imem_pkg.sv
// Shared widths and FSM state encoding for the instruction-memory loader.
// Imported by the loader top, its interface and the checksum accumulator.
package imem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Control, source-stream and InstructionMemory signals of the loader.
// master = loader side, slave = environment (source, memory, controller).
interface imem_loader_if #(
    parameter int ADDR_W = imem_pkg::ADDR_W_DEF,
    parameter int DATA_W = imem_pkg::DATA_W_DEF
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_wn;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_read_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    modport master (
        input  start, base_addr, word_count, s_data, s_valid, mem_read_data,
        output s_ready, mem_address, mem_write_data, mem_wn, mem_rd,
               busy, done, error, checksum
    );

    modport slave (
        output start, base_addr, word_count, s_data, s_valid, mem_read_data,
        input  s_ready, mem_address, mem_write_data, mem_wn, mem_rd,
               busy, done, error, checksum
    );
endinterface

// File: rtl/imem_sum_acc.sv
// Modulo-2^DATA_W running sum with synchronous clear; clear wins over enable.
// One-cycle update latency, no backpressure.
module imem_sum_acc
    import imem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_sum
);
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_dat;
        end
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/imem_loader.sv
// Streams words into InstructionMemory, reads them back and compares checksums.
// Memory strobes registered; s_ready is high only in WRITE, gaps in s_valid insert no writes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    imem_loader_if.master bus
);
    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_CHECK = ST_CHECK;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_checksum;
    logic              r_wn;
    logic              r_rd;
    logic              r_rd_d;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic              w_start_ok;
    logic              w_last;
    logic [DATA_W-1:0] w_wsum;
    logic [DATA_W-1:0] w_rsum;

    assign w_xfer     = (r_state == S_WRITE) && bus.s_valid;
    assign w_start_ok = (r_state == S_IDLE) && bus.start && (bus.word_count != '0);
    assign w_last     = (r_idx == r_count - ADDR_W'(1));

    imem_sum_acc #(.DATA_W(DATA_W)) u_wsum (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_ok),
        .i_en  (w_xfer),
        .i_dat (bus.s_data),
        .o_sum (w_wsum)
    );

    // r_rd_d marks the edge where read_data answers the previous rd cycle
    imem_sum_acc #(.DATA_W(DATA_W)) u_rsum (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_start_ok),
        .i_en  (r_rd_d),
        .i_dat (bus.mem_read_data),
        .o_sum (w_rsum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_checksum <= '0;
            r_wn       <= 1'b0;
            r_rd       <= 1'b0;
            r_rd_d     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wn   <= 1'b0;
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            r_rd_d <= r_rd;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_error    <= 1'b0;
                        r_checksum <= '0;
                        r_idx      <= '0;
                        if (bus.word_count != '0) begin
                            r_base  <= bus.base_addr;
                            r_count <= bus.word_count;
                            r_state <= S_WRITE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.s_valid) begin
                        r_wn    <= 1'b1;
                        r_addr  <= r_base + r_idx;
                        r_wdata <= bus.s_data;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                S_READ: begin
                    r_rd   <= 1'b1;
                    r_addr <= r_base + r_idx;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                // leave once the last rd cycle has retired; its sample lands on this edge
                S_DRAIN: begin
                    if (!r_rd) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_error    <= (w_rsum != w_wsum);
                    r_checksum <= w_wsum;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready        = (r_state == S_WRITE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.mem_address    = r_addr;
    assign bus.mem_write_data = r_wdata;
    assign bus.mem_wn         = r_wn;
    assign bus.mem_rd         = r_rd;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.checksum       = r_checksum;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected wn/rd/done events are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT emits them.
module tb_imem_loader;
    localparam int EV_WR   = 0;
    localparam int EV_RD   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    bit   mon_en = 1'b0;
    bit   corrupt_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic [31:0] wdat [0:7];
    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // InstructionMemory model: registered read, optional bit-0 corruption at address 2
    always @(posedge clk) begin
        if (bus.mem_wn === 1'b1) mem[bus.mem_address] <= bus.mem_write_data;
        if (bus.mem_rd === 1'b1)
            bus.mem_read_data <= mem[bus.mem_address] ^
                ((corrupt_en && bus.mem_address == 16'd2) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input logic [15:0] addr, input logic [31:0] data,
                            input logic err);
        exp_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none",
                     kind, addr, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind != EV_DONE && e.addr !== addr) ||
                (kind != EV_RD && e.data !== data) || (kind == EV_DONE && e.err !== err)) begin
                n_fail++;
                $display("FAIL event: got kind %0d addr %h data %h err %b, expected kind %0d addr %h data %h err %b",
                         kind, addr, data, err, e.kind, e.addr, e.data, e.err);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_wn === 1'b1 && bus.mem_rd === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL wn_rd_overlap: got wn=1 rd=1, expected never both");
            end
            if (bus.mem_wn === 1'b1) check_ev(EV_WR, bus.mem_address, bus.mem_write_data, 1'b0);
            if (bus.mem_rd === 1'b1) check_ev(EV_RD, bus.mem_address, 32'h0, 1'b0);
            if (bus.done === 1'b1)   check_ev(EV_DONE, 16'h0, bus.checksum, bus.error);
        end
    end

    task automatic expect_load(input logic [15:0] base, input int n, input logic [31:0] cks,
                               input logic err);
        for (int i = 0; i < n; i++) q.push_back('{EV_WR, base + 16'(i), wdat[i], 1'b0});
        for (int i = 0; i < n; i++) q.push_back('{EV_RD, base + 16'(i), 32'h0, 1'b0});
        q.push_back('{EV_DONE, 16'h0, cks, err});
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] n);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.word_count = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        while (bus.s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready=%b after %0d cycles, expected 1", bus.s_ready, t);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((q.size() != 0 || bus.busy !== 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_completes"}, 64'(t < 200), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_load(input string name, input logic [15:0] base, input int n,
                            input logic [31:0] cks, input logic err, input bit gaps);
        expect_load(base, n, cks, err);
        do_start(base, 16'(n));
        for (int i = 0; i < n; i++) begin
            send_word(wdat[i]);
            if (gaps) begin
                bus.start = 1'b1;
                bus.base_addr = 16'h0300;
                bus.word_count = 16'd2;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        wait_idle(name);
        chk({name, "_checksum_held"}, bus.checksum, cks);
        chk({name, "_error_held"}, bus.error, err);
        chk({name, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_s_ready"}, bus.s_ready, 0);
        chk({name, "_wn"}, bus.mem_wn, 0);
        chk({name, "_rd"}, bus.mem_rd, 0);
        chk({name, "_addr"}, bus.mem_address, 0);
        chk({name, "_wdata"}, bus.mem_write_data, 0);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_done"}, bus.done, 0);
        chk({name, "_error"}, bus.error, 0);
        chk({name, "_checksum"}, bus.checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // basic five-word load, s_valid held high
        wdat[0] = 32'h0; wdat[1] = 32'h1; wdat[2] = 32'h10; wdat[3] = 32'h6; wdat[4] = 32'h12;
        run_load("basic", 16'h0000, 5, 32'h29, 1'b0, 1'b0);

        // zero-length load: done next cycle, no memory access, checksum cleared
        q.push_back('{EV_DONE, 16'h0, 32'h0, 1'b0});
        do_start(16'h1234, 16'h0);
        chk("zero_done_pulse", bus.done, 1);
        chk("zero_not_busy", bus.busy, 0);
        @(negedge clk);
        chk("zero_done_one_cycle", bus.done, 0);
        chk("zero_checksum", bus.checksum, 0);
        chk("zero_error", bus.error, 0);
        chk("zero_queue_empty", q.size(), 0);

        // address wrap FFFE, FFFF, 0000 and carry-discarding sum
        wdat[0] = 32'h11111111; wdat[1] = 32'h22222222; wdat[2] = 32'hF0000000;
        run_load("wrap", 16'hFFFE, 3, 32'h23333333, 1'b0, 1'b0);

        // readback corruption at address 2
        corrupt_en = 1'b1;
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        run_load("corrupt", 16'h0000, 4, 32'hAA, 1'b1, 1'b0);
        corrupt_en = 1'b0;

        // s_valid toggling with start pulses while busy; sum wraps modulo 2^32
        wdat[0] = 32'hFFFFFFFF; wdat[1] = 32'h2; wdat[2] = 32'h80000000; wdat[3] = 32'h80000000;
        run_load("backpressure", 16'h0020, 4, 32'h1, 1'b0, 1'b1);

        // reset after the second of five transfers
        wdat[0] = 32'hA0; wdat[1] = 32'hA1;
        q.push_back('{EV_WR, 16'h0040, 32'hA0, 1'b0});
        q.push_back('{EV_WR, 16'h0041, 32'hA1, 1'b0});
        do_start(16'h0040, 16'd5);
        send_word(wdat[0]);
        send_word(wdat[1]);
        rst_n = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 32'hA2;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        rst_n = 1'b1;
        bus.s_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midload_stays_idle", bus.busy, 0);
        chk("midload_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
